// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the M-stage exception controller: cause codes,
// FSM state encoding and the default exception vector.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    typedef enum logic {
        ST_IDLE,
        ST_REDIR
    } state_t;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority cause encoder: picks the highest-priority pending cause
// and reports whether BadVAddr comes from the PC or the data address.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic      interrupt,
    input  logic      f_adel,
    input  logic      d_ri,
    input  logic      d_syscall,
    input  logic      d_break,
    input  logic      e_ov,
    input  logic      m_adel,
    input  logic      m_ades,
    output logic      any,
    output exc_code_t code,
    output logic      bad_from_pc,
    output logic      bad_from_addr
);

    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch in combinational logic).
    always_comb begin
        any           = 1'b1;
        code          = EXC_INT;
        bad_from_pc   = 1'b0;
        bad_from_addr = 1'b0;
        if (interrupt) begin
            code = EXC_INT;
        end else if (f_adel) begin
            code        = EXC_ADEL;
            bad_from_pc = 1'b1;
        end else if (d_ri) begin
            code = EXC_RI;
        end else if (d_syscall) begin
            code = EXC_SYS;
        end else if (d_break) begin
            code = EXC_BP;
        end else if (e_ov) begin
            code = EXC_OV;
        end else if (m_adel) begin
            code          = EXC_ADEL;
            bad_from_addr = 1'b1;
        end else if (m_ades) begin
            code          = EXC_ADES;
            bad_from_addr = 1'b1;
        end else begin
            any = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception/interrupt controller: drives CP0 capture, kills and
// flushes the pipe, then holds a redirect PC toward fetch until accepted.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_in_delay_slot,
    input  logic        m_is_eret,
    input  logic [31:0] m_addr,
    input  logic        f_adel,
    input  logic        d_ri,
    input  logic        d_syscall,
    input  logic        d_break,
    input  logic        e_ov,
    input  logic        m_adel,
    input  logic        m_ades,
    input  logic        interrupt,
    input  logic [31:0] cp0_epc,
    input  logic        redir_ready,
    output logic        exception,
    output logic [5:0]  m_excCode,
    output logic        isBadAddr,
    output logic [31:0] invalid_addr,
    output logic [31:0] excPC,
    output logic        inDelaySlot,
    output logic        ERET2pc,
    output logic        kill_m,
    output logic        flush,
    output logic        stall_all,
    output logic        redir_valid,
    output logic [31:0] redir_pc
);

    state_t      state_q, state_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic      prio_any, prio_bad_pc, prio_bad_addr;
    exc_code_t prio_code;
    logic      take, eret;

    exc_prio u_prio (
        .interrupt     (interrupt),
        .f_adel        (f_adel),
        .d_ri          (d_ri),
        .d_syscall     (d_syscall),
        .d_break       (d_break),
        .e_ov          (e_ov),
        .m_adel        (m_adel),
        .m_ades        (m_ades),
        .any           (prio_any),
        .code          (prio_code),
        .bad_from_pc   (prio_bad_pc),
        .bad_from_addr (prio_bad_addr)
    );

    // Bubbles never trigger, and nothing triggers while reset is held.
    assign take = resetn && (state_q == ST_IDLE) && m_valid && prio_any;
    assign eret = resetn && (state_q == ST_IDLE) && m_valid && m_is_eret && !take;

    always_comb begin
        state_d      = state_q;
        redir_pc_d   = redir_pc_q;
        exception    = 1'b0;
        m_excCode    = 6'd0;
        isBadAddr    = 1'b0;
        invalid_addr = 32'd0;
        excPC        = 32'd0;
        inDelaySlot  = 1'b0;
        ERET2pc      = 1'b0;
        kill_m       = 1'b0;
        flush        = 1'b0;
        stall_all    = 1'b0;
        redir_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    exception   = 1'b1;
                    m_excCode   = {1'b0, prio_code};
                    excPC       = m_pc;
                    inDelaySlot = m_in_delay_slot;
                    kill_m      = 1'b1;
                    flush       = 1'b1;
                    if (prio_bad_pc) begin
                        isBadAddr    = 1'b1;
                        invalid_addr = m_pc;
                    end else if (prio_bad_addr) begin
                        isBadAddr    = 1'b1;
                        invalid_addr = m_addr;
                    end
                    redir_pc_d = EXC_VECTOR;
                    state_d    = ST_REDIR;
                end else if (eret) begin
                    ERET2pc    = 1'b1;
                    flush      = 1'b1;
                    redir_pc_d = cp0_epc;
                    state_d    = ST_REDIR;
                end
            end
            ST_REDIR: begin
                // Pipeline is frozen; incoming flags belong to stale slots.
                redir_valid = 1'b1;
                stall_all   = 1'b1;
                if (redir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign redir_pc = redir_pc_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

endmodule
